// File: rtl/fpu_pkg.sv
// Shared FPU definitions: special values, widths and the adder state encoding.
// Imported by the fp_add_seq slice.
package fpu_pkg;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    localparam int EXP_BIAS = 127;
    localparam int MANT_W   = 24;
    localparam int EXT_W    = 27;

    // First biased exponent that no longer encodes a finite value.
    localparam logic [9:0] EXP_MAX = 10'(2 * EXP_BIAS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

endpackage

// File: rtl/fp_add_seq_if.sv
// Operand/result handshake bundle for fp_add_seq.
// The sub signal exists only when FPADD_SUB_EN is defined.
interface fp_add_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
`ifdef FPADD_SUB_EN
    logic        sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
`ifdef FPADD_SUB_EN
        output sub,
`endif
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
`ifdef FPADD_SUB_EN
        input  sub,
`endif
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/fp_unpack.sv
// Splits an FP32 word into sign, exponent and 24-bit mantissa with the
// hidden bit, and classifies zero/subnormal, infinity and NaN.
module fp_unpack
    import fpu_pkg::*;
(
    input  logic [31:0]       word,
    output logic              sign,
    output logic [7:0]        exp,
    output logic [MANT_W-1:0] mant,
    output logic              is_zero,
    output logic              is_inf,
    output logic              is_nan
);

    // Field split and classification; exp==0 is treated as zero.
    always_comb begin
        sign    = word[31];
        exp     = word[30:23];
        mant    = {(word[30:23] != 8'd0), word[22:0]};
        is_zero = (word[30:23] == 8'd0);
        is_inf  = (&word[30:23]) && (word[22:0] == 23'd0);
        is_nan  = (&word[30:23]) && (word[22:0] != 23'd0);
    end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle FP32 adder: unpack, align, add, normalize, round.
// Optional macro FPADD_SUB_EN adds the sub input (a - b).
module fp_add_seq
    import fpu_pkg::*;
#(
    parameter int NORM_MAX = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_add_seq_if.slave   bus
);

    localparam logic [5:0] NMAX = 6'(NORM_MAX);

    state_t            state;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
`ifdef FPADD_SUB_EN
    logic              sub_q;
`endif
    logic              sign_a;
    logic              sign_b;
    logic [7:0]        exp_a;
    logic [7:0]        exp_b;
    logic [MANT_W-1:0] mant_a;
    logic [MANT_W-1:0] mant_b;
    logic [EXT_W-1:0]  m_a;
    logic [EXT_W-1:0]  m_b;
    logic [EXT_W-1:0]  sum;
    logic [9:0]        exp_r;
    logic [5:0]        norm_cnt;

    logic              ua_sign;
    logic [7:0]        ua_exp;
    logic [MANT_W-1:0] ua_mant;
    logic              ua_zero;
    logic              ua_inf;
    logic              ua_nan;
    logic              ub_sign;
    logic [7:0]        ub_exp;
    logic [MANT_W-1:0] ub_mant;
    logic              ub_zero;
    logic              ub_inf;
    logic              ub_nan;

    logic              sb;
    logic              swap;
    logic [7:0]        d;
    logic [EXT_W-1:0]  ext_b;
    logic [EXT_W-1:0]  shifted_b;
    logic [EXT_W-1:0]  sum_w;
    logic [EXT_W-1:0]  shl;
    logic [9:0]        exp_dec;
    logic [5:0]        cnt_inc;
    logic [MANT_W:0]   mant_rnd;
    logic [22:0]       mant_fin;
    logic [9:0]        exp_fin;

    fp_unpack u_unpack_a (
        .word    (a_q),
        .sign    (ua_sign),
        .exp     (ua_exp),
        .mant    (ua_mant),
        .is_zero (ua_zero),
        .is_inf  (ua_inf),
        .is_nan  (ua_nan)
    );

    fp_unpack u_unpack_b (
        .word    (b_q),
        .sign    (ub_sign),
        .exp     (ub_exp),
        .mant    (ub_mant),
        .is_zero (ub_zero),
        .is_inf  (ub_inf),
        .is_nan  (ub_nan)
    );

`ifdef FPADD_SUB_EN
    assign sb = ub_sign ^ sub_q;
`else
    assign sb = ub_sign;
`endif

    assign swap = {ub_exp, ub_mant} > {ua_exp, ua_mant};

    // Per-state datapath: alignment shift, add/sub, normalize step, rounding.
    always_comb begin
        d         = exp_a - exp_b;
        ext_b     = {1'b0, mant_b, 2'b00};
        shifted_b = (d >= 8'd26) ? '0 : (ext_b >> d);
        sum_w     = (sign_a == sign_b) ? (m_a + m_b) : (m_a - m_b);
        shl       = sum << 1;
        exp_dec   = exp_r - 10'd1;
        cnt_inc   = norm_cnt + 6'd1;
        mant_rnd  = {1'b0, sum[25:2]} + {{MANT_W{1'b0}}, sum[1]};
        if (mant_rnd[MANT_W]) begin
            mant_fin = mant_rnd[23:1];
            exp_fin  = exp_r + 10'd1;
        end else begin
            mant_fin = mant_rnd[22:0];
            exp_fin  = exp_r;
        end
    end

    // Control FSM with registered handshake outputs and datapath state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.busy      <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
`ifdef FPADD_SUB_EN
            sub_q         <= 1'b0;
`endif
            sign_a        <= 1'b0;
            sign_b        <= 1'b0;
            exp_a         <= '0;
            exp_b         <= '0;
            mant_a        <= '0;
            mant_b        <= '0;
            m_a           <= '0;
            m_b           <= '0;
            sum           <= '0;
            exp_r         <= '0;
            norm_cnt      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid) begin
                        a_q          <= bus.a;
                        b_q          <= bus.b;
`ifdef FPADD_SUB_EN
                        sub_q        <= bus.sub;
`endif
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    state <= S_DONE;
                    bus.out_valid <= 1'b1;
                    if (ua_nan || ub_nan) begin
                        bus.result <= QNAN;
                    end else if (ua_inf && ub_inf && (ua_sign != sb)) begin
                        bus.result <= QNAN;
                    end else if (ua_inf) begin
                        bus.result <= ua_sign ? NEG_INF : POS_INF;
                    end else if (ub_inf) begin
                        bus.result <= sb ? NEG_INF : POS_INF;
                    end else if (ua_zero && ub_zero) begin
                        bus.result <= {ua_sign & sb, 31'd0};
                    end else if (ua_zero) begin
                        bus.result <= {sb, b_q[30:0]};
                    end else if (ub_zero) begin
                        bus.result <= a_q;
                    end else begin
                        state         <= S_ALIGN;
                        bus.out_valid <= 1'b0;
                        if (swap) begin
                            sign_a <= sb;
                            exp_a  <= ub_exp;
                            mant_a <= ub_mant;
                            sign_b <= ua_sign;
                            exp_b  <= ua_exp;
                            mant_b <= ua_mant;
                        end else begin
                            sign_a <= ua_sign;
                            exp_a  <= ua_exp;
                            mant_a <= ua_mant;
                            sign_b <= sb;
                            exp_b  <= ub_exp;
                            mant_b <= ub_mant;
                        end
                    end
                end
                S_ALIGN: begin
                    m_a   <= {1'b0, mant_a, 2'b00};
                    m_b   <= shifted_b;
                    exp_r <= {2'b00, exp_a};
                    state <= S_ADD;
                end
                S_ADD: begin
                    norm_cnt <= '0;
                    if (sum_w == '0) begin
                        bus.result    <= '0;
                        bus.out_valid <= 1'b1;
                        state         <= S_DONE;
                    end else if (sum_w[26]) begin
                        sum   <= sum_w >> 1;
                        exp_r <= exp_r + 10'd1;
                        state <= S_ROUND;
                    end else if (sum_w[25]) begin
                        sum   <= sum_w;
                        state <= S_ROUND;
                    end else begin
                        sum   <= sum_w;
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    sum      <= shl;
                    exp_r    <= exp_dec;
                    norm_cnt <= cnt_inc;
                    if ((exp_dec == 10'd0) || (cnt_inc >= NMAX)) begin
                        bus.result    <= {sign_a, 31'd0};
                        bus.out_valid <= 1'b1;
                        state         <= S_DONE;
                    end else if (shl[25]) begin
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (exp_fin >= EXP_MAX) begin
                        bus.result <= sign_a ? NEG_INF : POS_INF;
                    end else begin
                        bus.result <= {sign_a, exp_fin[7:0], mant_fin};
                    end
                    bus.out_valid <= 1'b1;
                    state         <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: vector table with scoreboard,
// plus backpressure and mid-transaction reset sequences.
module tb_fp_add_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fp_add_seq_if bus ();

    fp_add_seq #(.NORM_MAX(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %08h want %08h", nm, got, want);
    endtask

    // Present one operand pair and hold it until the DUT accepts it.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) check("accept_timeout", 32'd0, 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Wait for a result, compare against the scoreboard, optionally ack.
    task automatic collect(input string nm, input int lat, input bit ack);
        int          cnt = 1;
        logic [31:0] want;
        while (bus.out_valid !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        want = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        if (bus.out_valid !== 1'b1) begin
            check({nm, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check(nm, bus.result, want);
        if (lat >= 0) check({nm, "_lat"}, cnt, lat);
        if (ack) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        bit ok;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
`ifdef FPADD_SUB_EN
        bus.sub       = 1'b0;
`endif

        tbl.push_back('{32'h3F800000, 32'h40000000, 32'h40400000, 5, "one_plus_two"});
        tbl.push_back('{32'h40000000, 32'h3F800000, 32'h40400000, 5, "two_plus_one"});
        tbl.push_back('{32'h3F800000, 32'hBF800000, 32'h00000000, -1, "cancel"});
        tbl.push_back('{32'h80000000, 32'h80000000, 32'h80000000, 2, "negz_negz"});
        tbl.push_back('{32'h00000000, 32'h80000000, 32'h00000000, 2, "posz_negz"});
        tbl.push_back('{32'h3F800001, 32'hBF800000, 32'h34000000, 28, "norm23"});
        tbl.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5, "ovf_add"});
        tbl.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000, 2, "inf_minus_inf"});
        tbl.push_back('{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 2, "nan_in"});
        tbl.push_back('{32'hFF800000, 32'h3F800000, 32'hFF800000, 2, "neg_inf"});
        tbl.push_back('{32'h3F800000, 32'h00000000, 32'h3F800000, 2, "x_plus_zero"});
        tbl.push_back('{32'h3F800000, 32'h30800000, 32'h3F800000, 5, "far_shift"});
        tbl.push_back('{32'h3F800000, 32'h33800000, 32'h3F800001, 5, "tie_away"});
        tbl.push_back('{32'hC0000000, 32'h3F800000, 32'hBF800000, 6, "norm1_neg"});
        tbl.push_back('{32'h40400000, 32'h3F800000, 32'h40800000, 5, "carry"});
        tbl.push_back('{32'h4B7FFFFF, 32'h3F000000, 32'h4B800000, 5, "round_carry"});
        tbl.push_back('{32'h7F7FFFFF, 32'h73000000, 32'h7F800000, 5, "round_ovf"});
        tbl.push_back('{32'h80800001, 32'h00800000, 32'h80000000, 5, "underflow"});

        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            sb_q.push_back(tbl[i].exp);
            send(tbl[i].a, tbl[i].b);
            collect(tbl[i].name, tbl[i].lat, 1'b1);
        end

        // Backpressure: result and handshake outputs hold while stalled.
        sb_q.push_back(32'h40400000);
        send(32'h3F800000, 32'h40000000);
        collect("bp_first", 5, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 32'h7FC00000;
            bus.b        = 32'h7FC00000;
            @(negedge clk);
            if (bus.result !== 32'h40400000 || bus.in_ready !== 1'b0 ||
                bus.out_valid !== 1'b1 || bus.busy !== 1'b1)
                ok = 1'b0;
        end
        bus.in_valid = 1'b0;
        check("bp_stable", {31'd0, ok}, 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("bp_rel_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("bp_rel_busy", {31'd0, bus.busy}, 32'd0);

        // Reset during NORM discards the operation.
        send(32'h3F800001, 32'hBF800000);
        repeat (10) @(negedge clk);
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("mid_rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mid_rel_out_valid", {31'd0, bus.out_valid}, 32'd0);
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) ok = 1'b0;
        end
        check("mid_no_output", {31'd0, ok}, 32'd1);

        sb_q.push_back(32'h40800000);
        send(32'h40400000, 32'h3F800000);
        collect("after_reset", 5, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
